// File: rtl/state_dump_sequencer.sv
// state_dump_sequencer
//
// Streams a debug dump of the MIPS register bank and data memory into the
// UART TX FIFO write port. A start request in IDLE snapshots both flat
// content buses, then every byte is pushed out one at a time. Slot 0 goes
// first, and the bytes of each slot go most significant byte first. The
// sequencer waits whenever the FIFO reports full.
//
// Optional build macro: STATE_DUMP_SEQUENCER_CHECKSUM_EN
//   When it is defined, one extra byte follows the memory bytes. That byte
//   is the XOR of every register and memory byte in the current dump.
//
// Ports:
//   i_clk                 system clock
//   i_reset               synchronous, active-high reset (overrides i_start)
//   i_start               single-cycle dump request, honoured only in IDLE
//   i_uart_full           UART TX FIFO full (back-pressure)
//   i_registers_conntent  flat register bank, register n at [32n+31:32n]
//   i_memory_conntent     flat data memory, same slot layout
//   o_uart_wr             TX FIFO write strobe
//   o_uart_data_wr        byte presented to the FIFO
//   o_busy                dump in progress (SNAP through the last byte)
//   o_done                one-cycle pulse after the last byte is accepted
//   o_dbg_state           current FSM state, for debug and checkers
//
// Handshake: o_uart_wr acts as valid and !i_uart_full acts as ready.
// o_uart_wr only rises when the FIFO can take the byte, so every cycle
// with o_uart_wr=1 is a completed transfer. o_uart_data_wr stays stable
// until that transfer happens.
module state_dump_sequencer #(
    parameter int UART_BUS_SIZE          = 8,
    parameter int REGISTER_SIZE          = 32,
    parameter int REGISTER_BANK_BUS_SIZE = 1024,
    parameter int MEMORY_SLOT_SIZE       = 32,
    parameter int MEMORY_DATA_BUS_SIZE   = 1024
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_start,
    input  logic                              i_uart_full,
    input  logic [REGISTER_BANK_BUS_SIZE-1:0] i_registers_conntent,
    input  logic [MEMORY_DATA_BUS_SIZE-1:0]   i_memory_conntent,
    output logic                              o_uart_wr,
    output logic [UART_BUS_SIZE-1:0]          o_uart_data_wr,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [2:0]                        o_dbg_state
);

    localparam int unsigned REG_BYTES = REGISTER_BANK_BUS_SIZE / UART_BUS_SIZE;
    localparam int unsigned MEM_BYTES = MEMORY_DATA_BUS_SIZE / UART_BUS_SIZE;
    localparam int unsigned MAX_BYTES = (REG_BYTES > MEM_BYTES) ? REG_BYTES : MEM_BYTES;
    localparam int unsigned CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int unsigned REG_BPS   = REGISTER_SIZE / UART_BUS_SIZE;
    localparam int unsigned MEM_BPS   = MEMORY_SLOT_SIZE / UART_BUS_SIZE;

    localparam logic [CNT_W-1:0] REG_LAST = CNT_W'(REG_BYTES - 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SNAP     = 3'd1,
        S_SEND_REG = 3'd2,
        S_SEND_MEM = 3'd3,
        S_CHK      = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [UART_BUS_SIZE-1:0]          data_q, data_d;
    logic [REGISTER_BANK_BUS_SIZE-1:0] reg_snap_q, reg_snap_d;
    logic [MEMORY_DATA_BUS_SIZE-1:0]   mem_snap_q, mem_snap_d;
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
    logic [UART_BUS_SIZE-1:0]          acc_q, acc_d;
`endif

    logic sending;
    logic accept;

    // Byte idx of the register bus. Slot = idx / bytes-per-slot, and byte 0
    // of a slot is its most significant byte.
    function automatic logic [UART_BUS_SIZE-1:0] reg_byte(
        input logic [REGISTER_BANK_BUS_SIZE-1:0] bus,
        input logic [CNT_W-1:0]                  idx
    );
        int unsigned                       slot;
        int unsigned                       k;
        int unsigned                       off;
        logic [REGISTER_BANK_BUS_SIZE-1:0] sh;
        slot = 32'(idx) / REG_BPS;
        k    = 32'(idx) % REG_BPS;
        off  = slot * REGISTER_SIZE + (REG_BPS - 1 - k) * UART_BUS_SIZE;
        sh   = bus >> off;
        return sh[UART_BUS_SIZE-1:0];
    endfunction

    function automatic logic [UART_BUS_SIZE-1:0] mem_byte(
        input logic [MEMORY_DATA_BUS_SIZE-1:0] bus,
        input logic [CNT_W-1:0]                idx
    );
        int unsigned                     slot;
        int unsigned                     k;
        int unsigned                     off;
        logic [MEMORY_DATA_BUS_SIZE-1:0] sh;
        slot = 32'(idx) / MEM_BPS;
        k    = 32'(idx) % MEM_BPS;
        off  = slot * MEMORY_SLOT_SIZE + (MEM_BPS - 1 - k) * UART_BUS_SIZE;
        sh   = bus >> off;
        return sh[UART_BUS_SIZE-1:0];
    endfunction

    assign sending = (state_q == S_SEND_REG) || (state_q == S_SEND_MEM) ||
                     (state_q == S_CHK);
    // Combinational from i_uart_full. A full FIFO stalls the stream in the
    // same cycle.
    assign accept  = sending && !i_uart_full;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            reg_snap_q <= '0;
            mem_snap_q <= '0;
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            reg_snap_q <= reg_snap_d;
            mem_snap_q <= mem_snap_d;
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
            acc_q      <= acc_d;
`endif
        end
    end

    // Next state. data_d always loads the byte that belongs to the next
    // (state, counter) pair, so data_q already holds the right byte in the
    // first cycle of each send state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        reg_snap_d = reg_snap_q;
        mem_snap_d = mem_snap_q;
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
        acc_d      = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_SNAP;
                end
            end
            S_SNAP: begin
                reg_snap_d = i_registers_conntent;
                mem_snap_d = i_memory_conntent;
                cnt_d      = '0;
                // The snapshot is still being loaded, so take byte 0 straight
                // from the live bus.
                data_d     = reg_byte(i_registers_conntent, '0);
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
                acc_d      = '0;
`endif
                state_d    = S_SEND_REG;
            end
            S_SEND_REG: begin
                if (accept) begin
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
                    acc_d = acc_q ^ data_q;
`endif
                    if (cnt_q == REG_LAST) begin
                        cnt_d   = '0;
                        data_d  = mem_byte(mem_snap_q, '0);
                        state_d = S_SEND_MEM;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        data_d = reg_byte(reg_snap_q, cnt_q + 1'b1);
                    end
                end
            end
            S_SEND_MEM: begin
                if (accept) begin
                    if (cnt_q == MEM_LAST) begin
                        cnt_d   = '0;
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
                        // The checksum byte includes this final memory byte.
                        acc_d   = acc_q ^ data_q;
                        data_d  = acc_q ^ data_q;
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
                        acc_d  = acc_q ^ data_q;
`endif
                        cnt_d  = cnt_q + 1'b1;
                        data_d = mem_byte(mem_snap_q, cnt_q + 1'b1);
                    end
                end
            end
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                // Any i_start in this cycle is dropped.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        o_uart_wr      = accept;
        o_uart_data_wr = data_q;
        o_busy         = (state_q == S_SNAP) || sending;
        o_done         = (state_q == S_DONE);
        o_dbg_state    = state_q;
    end

endmodule

// File: tb/tb_state_dump_sequencer.sv
module tb_state_dump_sequencer;

  localparam int RB = 1024;
  localparam int MB = 1024;
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
  localparam int TOTAL = RB / 8 + MB / 8 + 1;
`else
  localparam int TOTAL = RB / 8 + MB / 8;
`endif
  localparam int LIMIT = 3000;

  localparam int M_BASIC = 0;
  localparam int M_BP    = 1;
  localparam int M_BUSY  = 2;
  localparam int M_SNAP  = 3;
  localparam int M_RESET = 4;
  localparam int M_RAND  = 5;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic          i_uart_full;
  logic [RB-1:0] regs_bus;
  logic [MB-1:0] mem_bus;
  logic          o_uart_wr;
  logic [7:0]    o_uart_data_wr;
  logic          o_busy;
  logic          o_done;
  logic [2:0]    o_dbg_state;

  logic [31:0] reg_w[32];
  logic [31:0] mem_w[32];
  logic [7:0]  exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  state_dump_sequencer dut (
    .i_clk                (clk),
    .i_reset              (i_reset),
    .i_start              (i_start),
    .i_uart_full          (i_uart_full),
    .i_registers_conntent (regs_bus),
    .i_memory_conntent    (mem_bus),
    .o_uart_wr            (o_uart_wr),
    .o_uart_data_wr       (o_uart_data_wr),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_dbg_state          (o_dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // stimulus patterns
  task automatic set_pattern(input int kind);
    for (int n = 0; n < 32; n++) begin
      case (kind)
        0: begin
          reg_w[n] = 32'(n * 256 + n);
          mem_w[n] = 32'hA5A5_0000 + 32'(n);
        end
        1: begin
          reg_w[n] = $urandom;
          mem_w[n] = $urandom;
        end
        default: begin
          reg_w[n] = 32'h0;
          mem_w[n] = 32'h0;
        end
      endcase
    end
    if (kind == 2) begin
      reg_w[1] = 32'h0000_00FF;
      mem_w[0] = 32'h0F00_0000;
    end
    regs_bus = '0;
    mem_bus  = '0;
    for (int n = 31; n >= 0; n--) begin
      regs_bus = {regs_bus[RB-33:0], reg_w[n]};
      mem_bus  = {mem_bus[MB-33:0], mem_w[n]};
    end
  endtask

  // reference model: every word in slot order, bytes MSB first
  task automatic build_expected();
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
    logic [7:0] acc;
    acc = 8'h00;
`endif
    exp_q.delete();
    for (int n = 0; n < 32; n++)
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(8'(reg_w[n] >> (24 - 8 * k)));
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
        acc = acc ^ 8'(reg_w[n] >> (24 - 8 * k));
`endif
      end
    for (int n = 0; n < 32; n++)
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(8'(mem_w[n] >> (24 - 8 * k)));
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
        acc = acc ^ 8'(mem_w[n] >> (24 - 8 * k));
`endif
      end
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
    exp_q.push_back(acc);
`endif
  endtask

  task automatic check_idle(input string tag, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      check({tag, "_wr"}, o_uart_wr, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_done"}, o_done, 0);
      @(posedge clk); #1;
    end
  endtask

  // driver: one complete dump, scoring each write against exp_q
  task automatic run_dump(input int mode);
    int written, cyc, first_wr, last_wr, stall_a, stall_b;
    bit done_seen, p40, start_next, aborted;
    written = 0; cyc = 0; first_wr = -1; last_wr = -1; stall_a = 0; stall_b = 0;
    done_seen = 0; p40 = 0; start_next = 0; aborted = 0;
    build_expected();
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    while (!done_seen && !aborted && cyc < LIMIT) begin
      i_start = start_next;
      start_next = 0;
      if (mode == M_BUSY && written == 40 && !p40) begin
        i_start = 1'b1;
        p40 = 1;
      end
      if (mode == M_SNAP && cyc == 1) begin
        regs_bus = ~regs_bus;
        mem_bus  = ~mem_bus;
      end
      if (mode == M_RESET && written == 100) i_reset = 1'b1;
      case (mode)
        M_BP: begin
          if (written == 5 && stall_a < 10) begin
            i_uart_full = 1'b1;
            stall_a++;
          end else if (written == TOTAL - 1 && stall_b < 4) begin
            i_uart_full = 1'b1;
            stall_b++;
          end else begin
            i_uart_full = 1'b0;
          end
        end
        M_RAND:  i_uart_full = ($urandom_range(0, 3) == 0);
        default: i_uart_full = 1'b0;
      endcase
      @(negedge clk);
      if (!o_done) check("busy", o_busy, 1);
      if (cyc >= 1 && written < TOTAL && i_uart_full) begin
        check("stall_wr", o_uart_wr, 0);
        check("stall_hold", o_uart_data_wr, exp_q[0]);
      end
      if (o_uart_wr) begin
        if (exp_q.size() == 0) check("extra_wr", 1, 0);
        else check($sformatf("byte%0d", written), o_uart_data_wr, exp_q.pop_front());
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        written++;
        if (mode == M_BUSY && written == TOTAL) start_next = 1;
      end
      if (o_done) begin
        done_seen = 1;
        check("done_after_last", cyc - last_wr, 1);
        check("done_busy", o_busy, 0);
      end
      if (mode == M_RESET && i_reset) aborted = 1;
      @(posedge clk); #1;
      cyc++;
    end
    i_start = 1'b0;
    i_uart_full = 1'b0;
    if (aborted) begin
      i_reset = 1'b0;
      check_idle("after_rst", 3);
      exp_q.delete();
    end else begin
      check("done_seen", done_seen, 1);
      check("total_bytes", written, TOTAL);
      check("exp_left", exp_q.size(), 0);
      if (mode != M_RAND) check("first_latency", first_wr, 1);
      check_idle("idle", 4);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_uart_full = 1'b0;
    regs_bus = '0;
    mem_bus = '0;
    repeat (3) @(posedge clk);
    #1;
    i_start = 1'b1;
    @(negedge clk);
    check("rst_wr", o_uart_wr, 0);
    check("rst_data", o_uart_data_wr, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_state", o_dbg_state, 0);
    @(posedge clk); #1;
    i_start = 1'b0;
    i_reset = 1'b0;
    check_idle("post_rst", 2);

    set_pattern(0);
    run_dump(M_BASIC);
    run_dump(M_BP);
    run_dump(M_BUSY);
    set_pattern(0);
    run_dump(M_SNAP);
    set_pattern(0);
    run_dump(M_RESET);
    run_dump(M_BASIC);
    for (int r = 0; r < 3; r++) begin
      set_pattern(1);
      run_dump(M_RAND);
    end
`ifdef STATE_DUMP_SEQUENCER_CHECKSUM_EN
    set_pattern(2);
    check("chk_model", exp_q.size(), TOTAL);
    run_dump(M_BASIC);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
